otter_fetch_queue: RTL and testbench

OTTER_FETCH_QUEUE -- requirements
Module: otter_fetch_queue

---
 rtl/otter_pkg.sv | 25 ++
 rtl/otter_fetch_queue.sv | 75 +++++++
 tb/tb_otter_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I major opcodes, the canonical NOP, and the
// fetch-queue entry layout used between fetch and decode.
package otter_pkg;

  localparam logic [31:0] NOP_IR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fq_entry_t;

endpackage

// File: rtl/otter_fetch_queue.sv
// Instruction queue between fetch and decode: a count-tracked circular buffer
// of {PC, IR} entries, flushable on redirect, with NOP presented when empty.
module otter_fetch_queue #(
  parameter int          DEPTH  = 4,
  parameter logic [31:0] NOP_IR = otter_pkg::NOP_IR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_ir,
  output logic                     if_ready,
  input  logic                     dq_ready,
  output logic                     dq_valid,
  output logic [31:0]              dq_pc,
  output logic [31:0]              dq_ir,
  output logic [6:0]               dq_opcode,
  output logic [2:0]               dq_func3,
  output logic [6:0]               dq_func7,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  otter_pkg::fq_entry_t mem [DEPTH];
  otter_pkg::fq_entry_t head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer must hold its data while ready is low. Ready on
  // the fetch side depends only on occupancy, never on dq_ready.
  assign if_ready = (count != FULL_COUNT);
  assign dq_valid = (count != '0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = dq_valid && dq_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: if_pc, ir: if_ir};
  end

  assign head      = mem[rd_ptr];
  assign dq_pc     = dq_valid ? head.pc : 32'h0;
  assign dq_ir     = dq_valid ? head.ir : NOP_IR;
  assign dq_opcode = dq_ir[6:0];
  assign dq_func3  = dq_ir[14:12];
  assign dq_func7  = dq_ir[31:25];

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Self-checking bench for otter_fetch_queue: a queue scoreboard predicts the
// head entry, occupancy and handshake outputs every cycle.
module tb_otter_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ir;
  logic        if_ready;
  logic        dq_ready;
  logic        dq_valid;
  logic [31:0] dq_pc;
  logic [31:0] dq_ir;
  logic [6:0]  dq_opcode;
  logic [2:0]  dq_func3;
  logic [6:0]  dq_func7;
  logic [2:0]  count;

  logic [63:0] exp_q[$];
  int          n_vec;
  int          n_err;

  otter_fetch_queue #(.DEPTH(DEPTH), .NOP_IR(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_ir     (if_ir),
    .if_ready  (if_ready),
    .dq_ready  (dq_ready),
    .dq_valid  (dq_valid),
    .dq_pc     (dq_pc),
    .dq_ir     (dq_ir),
    .dq_opcode (dq_opcode),
    .dq_func3  (dq_func3),
    .dq_func7  (dq_func7),
    .count     (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard's view of the queue.
  task automatic check_outputs();
    logic [63:0] head;
    int          sz;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : {32'h0, NOP};
    check("count",    64'(count),     64'(sz));
    check("if_ready", 64'(if_ready),  64'(sz != DEPTH));
    check("dq_valid", 64'(dq_valid),  64'(sz != 0));
    check("dq_pc",    64'(dq_pc),     64'(head[63:32]));
    check("dq_ir",    64'(dq_ir),     64'(head[31:0]));
    check("dq_opcode",64'(dq_opcode), 64'(head[6:0]));
    check("dq_func3", 64'(dq_func3),  64'(head[14:12]));
    check("dq_func7", 64'(dq_func7),  64'(head[31:25]));
  endtask

  // Driver: called at a negedge; applies inputs for one cycle, checks, then
  // updates the scoreboard at the posedge and returns at the next negedge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ir, input logic dr);
    logic push_m;
    logic pop_m;
    flush    = fl;
    if_valid = iv;
    if_pc    = pc;
    if_ir    = ir;
    dq_ready = dr;
    #1;
    check_outputs();
    push_m = iv && (exp_q.size() != DEPTH) && !fl;
    pop_m  = (exp_q.size() != 0) && dr && !fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop_m)  void'(exp_q.pop_front());
      if (push_m) exp_q.push_back({pc, ir});
    end
    @(negedge clk);
    flush    = 1'b0;
    if_valid = 1'b0;
    dq_ready = 1'b0;
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, $urandom(), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = 32'h0;
    if_ir    = 32'h0;
    dq_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_count",    64'(count),    64'(0));
    check("rst_if_ready", 64'(if_ready), 64'(1));
    check("rst_dq_valid", 64'(dq_valid), 64'(0));
    check("rst_dq_ir",    64'(dq_ir),    64'(NOP));
    check("rst_dq_pc",    64'(dq_pc),    64'(0));
    rst_n = 1'b1;

    // Single push, visible one cycle later
    step(1'b0, 1'b1, 32'h100, 32'h0050_0093, 1'b0);
    check("first_valid",  64'(dq_valid),  64'(1));
    check("first_pc",     64'(dq_pc),     64'h100);
    check("first_opcode", 64'(dq_opcode), 64'h13);
    check("first_func3",  64'(dq_func3),  64'(0));
    check("first_count",  64'(count),     64'(1));
    drain();

    // Fill to full, try a fifth push, drain in order
    for (int i = 0; i < DEPTH; i++) push_one(32'h200 + 32'(i * 4));
    check("full_count", 64'(count),    64'(DEPTH));
    check("full_ready", 64'(if_ready), 64'(0));
    step(1'b0, 1'b1, 32'hDEAD, 32'hDEAD, 1'b0);
    check("full_hold", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_pc", 64'(dq_pc), 64'(32'h200 + 32'(i * 4)));
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    check("empty_nop", 64'(dq_ir), 64'(NOP));

    // Full with push and pop offered: pop only, then push+pop
    for (int i = 0; i < DEPTH; i++) push_one(32'h300 + 32'(i * 4));
    step(1'b0, 1'b1, 32'h400, 32'h0000_0033, 1'b1);
    check("full_pop_only", 64'(count), 64'(DEPTH - 1));
    step(1'b0, 1'b1, 32'h404, 32'h0000_0033, 1'b1);
    check("pushpop_count", 64'(count), 64'(DEPTH - 1));
    drain();

    // Steady push+pop at count 2, pointers wrap
    push_one(32'h500);
    push_one(32'h504);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h600 + 32'(i * 4), $urandom(), 1'b1);
      check("steady_count", 64'(count), 64'(2));
    end
    drain();

    // Flush beats a same-cycle push and pop
    for (int i = 0; i < 3; i++) push_one(32'h700 + 32'(i * 4));
    step(1'b1, 1'b1, 32'hBAD0, 32'h0000_006F, 1'b1);
    check("flush_count", 64'(count),    64'(0));
    check("flush_valid", 64'(dq_valid), 64'(0));
    check("flush_ready", 64'(if_ready), 64'(1));
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("flush_nopush", 64'(dq_valid), 64'(0));

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      step(1'b0 || ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    end
    drain();

    // Asynchronous reset mid-cycle
    push_one(32'h800);
    push_one(32'h804);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(dq_valid), 64'(0));
    check("async_count", 64'(count),    64'(0));
    check("async_ready", 64'(if_ready), 64'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h900, 32'h0000_0037, 1'b0);
    check("post_rst_pc", 64'(dq_pc), 64'h900);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
